// File: rtl/div_pkg.sv
// Shared definitions for the divider-sharing controller.
// Contents: FSM state encoding, the divide-by-zero quotient pattern and the
// default operand width.
package div_pkg;

  localparam int DATAWIDTH_DEF = 8;

  // Wide enough for any supported DATAWIDTH; users truncate to their width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/div_share_ctrl_if.sv
// Bundle of the request, response and divider-side signals of div_share_ctrl.
// slave  : controller view (div_share_ctrl)
// master : environment view (requesters, response consumer, divider)
// Request operands are flat vectors; requester i uses [i*DATAWIDTH +: DATAWIDTH].
interface div_share_ctrl_if #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*DATAWIDTH-1:0] req_dividend;
  logic [NREQ*DATAWIDTH-1:0] req_divisor;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [DATAWIDTH-1:0]      rsp_quotient;
  logic [DATAWIDTH-1:0]      rsp_remainder;
  logic                      rsp_dbz;

  logic                      div_en;
  logic                      div_ready;
  logic [DATAWIDTH-1:0]      div_dividend;
  logic [DATAWIDTH-1:0]      div_divisor;
  logic [DATAWIDTH-1:0]      div_quotient;
  logic [DATAWIDTH-1:0]      div_remainder;
  logic                      div_vld;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
           div_ready, div_quotient, div_remainder, div_vld,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
           div_en, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
           div_ready, div_quotient, div_remainder, div_vld,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz,
           div_en, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  IDW   highest-priority index
//   grant     out NREQ  one-hot grant (zero when no request)
//   grant_idx out IDW   encoded grant index
//   any_req   out 1     at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_req
);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Walk from ptr upward, wrapping at NREQ; the first set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    any_req   = |req;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one sequential divider among NREQ requesters, round-robin.
// Ports:
//   clk   in   clock
//   rstn  in   asynchronous active-low reset
//   bus   slave view of div_share_ctrl_if (requests, response, divider)
//
// state | meaning
// IDLE  | arbitrating; accepts one request when the divider is idle
// ISSUE | one-cycle div_en pulse with registered operands
// WAIT  | waiting (unbounded) for the divider result pulse
// RESP  | response held on rsp_* until rsp_ready
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NREQ      = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input logic              clk,
  input logic              rstn,
  div_share_ctrl_if.slave  bus
);

  state_t               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [DATAWIDTH-1:0] dvd_q, dvd_d;
  logic [DATAWIDTH-1:0] dvs_q, dvs_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_idx;
  logic                 any_req;
  logic [NREQ-1:0]      req_ready_c;
  logic                 div_en_c;

  logic [DATAWIDTH-1:0] dvd_arr [NREQ];
  logic [DATAWIDTH-1:0] dvs_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign dvd_arr[i] = bus.req_dividend[i*DATAWIDTH +: DATAWIDTH];
    assign dvs_arr[i] = bus.req_divisor[i*DATAWIDTH +: DATAWIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dbz_d       = dbz_q;
    req_ready_c = '0;
    div_en_c    = 1'b0;
    case (state_q)
      IDLE: begin
        // grant only has bits where req_valid is set, so ready implies accept.
        if (bus.div_ready && any_req) begin
          req_ready_c = grant;
          id_d        = grant_idx;
          dvd_d       = dvd_arr[grant_idx];
          dvs_d       = dvs_arr[grant_idx];
          if (dvs_arr[grant_idx] == '0) begin
            quot_d  = DATAWIDTH'(DBZ_QUOTIENT);
            rem_d   = dvd_arr[grant_idx];
            dbz_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        div_en_c = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (bus.div_vld) begin
          quot_d  = bus.div_quotient;
          rem_d   = bus.div_remainder;
          dbz_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        // Pointer moves past the served requester only once it is delivered.
        if (bus.rsp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.div_en        = div_en_c;
  assign bus.div_dividend  = dvd_q;
  assign bus.div_divisor   = dvs_q;
  assign bus.rsp_valid     = (state_q == RESP);
  assign bus.rsp_id        = id_q;
  assign bus.rsp_quotient  = quot_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_dbz       = dbz_q;

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Round-robin controller that shares one radix-2 sequential divider (en/ready/vld_out interface) among NREQ requesters.
- Accepts one request at a time through a valid/ready handshake and issues a single-cycle start pulse to the divider.
- Captures the divider's one-cycle result pulse and returns the result tagged with the requester ID, held until the consumer accepts it.
- Divide-by-zero requests are handled locally and never reach the divider.

Parameters:
- DATAWIDTH, 8, operand/result width; must match the divider's DATAWIDTH.
- NREQ, 4, number of requesters, 2..16.
- IDW, 2, requester ID width, equal to clog2(NREQ).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_dividend  in  NREQ*DATAWIDTH  flat vector; requester i uses slice [i*DATAWIDTH +: DATAWIDTH]
- req_divisor  in  NREQ*DATAWIDTH  flat vector, same slicing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  IDW  requester ID of the result
- rsp_quotient  out  DATAWIDTH  quotient
- rsp_remainder  out  DATAWIDTH  remainder
- rsp_dbz  out  1  result came from a divide-by-zero request
- div_en  out  1  divider start, one-cycle pulse
- div_ready  in  1  divider idle
- div_dividend  out  DATAWIDTH  operand to divider, registered
- div_divisor  out  DATAWIDTH  operand to divider, registered
- div_quotient  in  DATAWIDTH  divider quotient
- div_remainder  in  DATAWIDTH  divider remainder
- div_vld  in  1  divider result valid, one-cycle pulse

Behaviour:
- Clock: one clock, clk. Reset: rstn is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; round-robin pointer 0. Reset mid-operation aborts the job with no response. The divider is reset by the same rstn.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration is combinational. The winner g is the first requester with req_valid=1, searching from the pointer upward and wrapping.
  - req_ready[g]=1 only in IDLE and only when div_ready=1; all other bits are 0.
  - On accept (req_valid[g] & req_ready[g]), latch operands and g.
  - If divisor==0: go to RESP with quotient all-ones, remainder=dividend, rsp_dbz=1.
  - Otherwise go to ISSUE.
- ISSUE: div_en=1 for exactly this cycle, unconditionally -> WAIT.
- WAIT:
  - div_en=0.
  - On div_vld=1, capture div_quotient/div_remainder, set rsp_dbz=0 -> RESP.
  - Wait is unbounded; there is no timeout.
- RESP:
  - rsp_valid=1; rsp_* stay stable until rsp_ready=1.
  - On handshake: pointer becomes (g+1) mod NREQ -> IDLE.
  - No new request is accepted in RESP, including the handshake cycle. Minimum spacing between accepts is 2 cycles (dbz) or 3 + divider latency (normal).
- Latency, accept to rsp_valid:
  - dbz: 1 cycle.
  - Normal: 1 (ISSUE) + divider latency + 1. With the reference divider at DATAWIDTH=8 this is 2*DATAWIDTH+3 cycles from div_en to div_vld.
- Pointer update: the pointer advances only on response handshake, never on accept. A requester whose req_valid drops while not granted loses nothing.
- Protocol assumptions:
  - Requesters hold req_valid and operands stable until accepted.
  - A div_vld arriving outside WAIT is ignored.
- Operands are driven from registers. div_dividend/div_divisor hold their value from accept until the next accept.
- rsp_id width is IDW; requester indices >= NREQ never occur.

Decomposition:
- Shared package div_pkg:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3) as a 2-bit typedef.
  - DBZ_QUOTIENT constant (all-ones).
  - Default DATAWIDTH.
- One sub-module: rr_arbiter.
  - Parameter NREQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded grant index, any_req.
  - Purely combinational.

Test Plan:
- Single request, NREQ=4, DATAWIDTH=8: req 1 sends 100/7 -> one div_en pulse; rsp_id=1, quotient=14, remainder=2, rsp_dbz=0; rsp_valid held 3 cycles while rsp_ready=0 with values stable.
- Divide by zero: req 2 sends 55/0 -> div_en never asserted; rsp_valid on the cycle after accept; quotient=8'hFF, remainder=55, rsp_dbz=1.
- Fairness: all four requesters hold valid continuously (operands 200/3, 9/9, 0/5, 255/1) -> grant order 0,1,2,3,0; results 66r2, 1r0, 0r0, 255r0.
- Pointer wrap and sparse requests: pointer=3, only req 0 and req 2 valid -> req 0 granted first, then req 2.
- Reset mid-operation: rstn low during WAIT -> all outputs 0 and state IDLE; after release, new request 10/3 returns quotient 3, remainder 1, and no stale response appears.
